vga_timing_gen: RTL
===================

// Module: vga_timing_gen
// PURPOSE
//  Upstream raster stage for the 640x480@60 VGA pipeline. Produces pix_x/pix_y, video_active,
//  hsync/vsync and a free-running frame counter from the 25.175 MHz pixel clock. These feed
//  the background/sprite renderers directly, so all outputs are registered and mutually aligned.
// PARAMETERS
//  H_VISIBLE    640  active pixels per line
//  H_FRONT      16   horizontal front porch (pixels)
//  H_SYNC       96   hsync pulse width (pixels)
//  H_BACK       48   horizontal back porch (pixels); H_TOTAL = sum = 800
//  V_VISIBLE    480  active lines per frame
//  V_FRONT      10   vertical front porch (lines)
//  V_SYNC       2    vsync pulse width (lines)
//  V_BACK       33   vertical back porch (lines); V_TOTAL = sum = 525
//  SYNC_POL     0    sync active level (0 = active-low, per 640x480 standard)
//  FRAME_W      10   width of frame counter
// PORTS
//  clk           in   1        pixel clock
//  rst_n         in   1        asynchronous active-low reset
//  pix_x         out  10       current column, 0..H_TOTAL-1
//  pix_y         out  10       current line, 0..V_TOTAL-1
//  video_active  out  1        1 when pix_x<H_VISIBLE && pix_y<V_VISIBLE
//  hsync         out  1        horizontal sync, level SYNC_POL when active
//  vsync         out  1        vertical sync, level SYNC_POL when active
//  line_start    out  1        1-cycle pulse when pix_x==0
//  frame_start   out  1        1-cycle pulse when pix_x==0 && pix_y==0
//  counter       out  FRAME_W  frame counter, increments on each frame_start
// BEHAVIOUR
//  - Reset (async assert, sync release): pix_x=H_TOTAL-1, pix_y=V_TOTAL-1, video_active=0,
//    hsync=vsync=~SYNC_POL, line_start=frame_start=0, counter=0. Reset parks the raster at
//    the last blanking pixel so the first edge after release lands on (0,0).
//  - Each clk: pix_x<=pix_x+1; at pix_x==H_TOTAL-1 pix_x<=0 and pix_y advances; pix_y wraps
//    V_TOTAL-1 -> 0. No other count values reachable.
//  - Decoded outputs are registered from the NEXT counter values, so at every cycle they
//    describe exactly the pix_x/pix_y presented that cycle (zero relative latency).
//  - hsync active for pix_x in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC) = [656,752).
//  - vsync active for pix_y in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC) = [490,492),
//    for whole lines (all pix_x of those lines).
//  - counter increments (mod 2^FRAME_W) in the same cycle frame_start is 1, including the
//    first (0,0) after reset: first displayed frame sees counter==1. 2^FRAME_W-1 wraps to 0.
//  - Reset mid-line/mid-frame: all outputs return to reset values immediately (async);
//    no partial sync pulse is extended after reset.
//  - Widths: pix_x/pix_y comparisons unsigned 10-bit; H_TOTAL, V_TOTAL must be <= 1024
//    (elaboration-time check).
// STRUCTURE
//  - Package vga_timing_pkg: default 640x480 timing constants, derived H_TOTAL/V_TOTAL,
//    sync window start/end constants shared with renderers.
//  - Sub-module vga_axis_counter (param TOTAL, SYNC_START, SYNC_END, VISIBLE): wrap counter
//    with inc enable, wrap flag, next-value visible/sync decode. Instantiated twice:
//    horizontal (inc=1) and vertical (inc=horizontal wrap).
// TESTING
//  - Reset: hold rst_n=0 -> pix_x=799, pix_y=524, video_active=0, hsync=vsync=1, counter=0;
//    release, 1 edge -> (0,0), video_active=1, line_start=frame_start=1, counter=1.
//  - Line wrap: at (799,10) next edge -> (0,11), line_start=1, frame_start=0.
//  - hsync edges: pix_x=655 hsync=1, 656 ->0, 751 ->0, 752 ->1; video_active 0 at pix_x=640.
//  - vsync: pix_y=489 vsync=1, 490..491 vsync=0 for all pix_x, 492 ->1; video_active 0 at y=480.
//  - Frame wrap with FRAME_W=2, small timings (H 4/1/1/1, V 3/1/1/1): counter 1,2,3,0,1 on
//    successive frame_start pulses; spacing H_TOTAL*V_TOTAL=7*6=42 cycles.
//  - Async reset asserted at (700,300) mid-cycle -> outputs jump to reset values before next
//    edge; after release raster restarts at (0,0), counter=1.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants for the 640x480@60 VGA pipeline.
// Renderers import this to agree with the timing generator on where
// the visible area and the sync windows sit.
package vga_timing_pkg;

  localparam int CNT_W = 10;  // pix_x / pix_y width
  typedef logic [CNT_W-1:0] coord_t;

  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;

  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;
  localparam int VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  // Sync windows are half-open: [START, END)
  localparam int VGA_H_SYNC_START = VGA_H_VISIBLE + VGA_H_FRONT;
  localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC;
  localparam int VGA_V_SYNC_START = VGA_V_VISIBLE + VGA_V_FRONT;
  localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC;

  localparam logic VGA_SYNC_POL = 1'b0;  // active-low syncs
  localparam int   VGA_FRAME_W  = 10;

  // Unsigned half-open window test on a coordinate.
  function automatic logic in_window(coord_t v, coord_t lo, coord_t hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster output bundle of the VGA timing generator.
//   pix_x/pix_y   current column/line
//   video_active  inside the visible area
//   hsync/vsync   sync levels (already polarity-adjusted)
//   line_start    1-cycle pulse at pix_x==0
//   frame_start   1-cycle pulse at (0,0)
//   counter       frame counter, bumps with frame_start
// master = timing generator, slave = renderer.
interface vga_timing_if #(parameter int FRAME_W = 10);
  import vga_timing_pkg::*;

  coord_t             pix_x;
  coord_t             pix_y;
  logic               video_active;
  logic               hsync;
  logic               vsync;
  logic               line_start;
  logic               frame_start;
  logic [FRAME_W-1:0] counter;

  modport master (
    output pix_x, pix_y, video_active, hsync, vsync,
           line_start, frame_start, counter
  );

  modport slave (
    input  pix_x, pix_y, video_active, hsync, vsync,
           line_start, frame_start, counter
  );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrap counter 0..TOTAL-1 with increment enable.
//   clk, rst_n    pixel clock, async active-low reset
//   i_inc         advance this cycle
//   o_cnt         registered count (resets to TOTAL-1)
//   o_wrap        this cycle's advance wraps TOTAL-1 -> 0
//   o_nxt_vis     next count < VISIBLE
//   o_nxt_sync    next count in [SYNC_START, SYNC_END)
// Decodes are on the next value so the parent can register them and
// have them line up with o_cnt.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int TOTAL      = VGA_H_TOTAL,
  parameter int VISIBLE    = VGA_H_VISIBLE,
  parameter int SYNC_START = VGA_H_SYNC_START,
  parameter int SYNC_END   = VGA_H_SYNC_END
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_inc,
  output coord_t o_cnt,
  output logic   o_wrap,
  output logic   o_nxt_vis,
  output logic   o_nxt_sync
);

  if (TOTAL > (1 << CNT_W) || TOTAL < 2) begin : g_chk_total
    $error("vga_axis_counter: TOTAL=%0d out of range 2..%0d", TOTAL, 1 << CNT_W);
  end

  localparam coord_t LAST   = coord_t'(TOTAL - 1);
  localparam coord_t VIS    = coord_t'(VISIBLE);
  localparam coord_t SYN_LO = coord_t'(SYNC_START);
  localparam coord_t SYN_HI = coord_t'(SYNC_END);

  coord_t r_cnt;
  coord_t w_nxt;
  logic   w_at_last;

  assign w_at_last = (r_cnt == LAST);

  always_comb begin
    w_nxt = r_cnt;
    if (i_inc) w_nxt = w_at_last ? '0 : r_cnt + 1'b1;
  end

  // Parked at the last count so the first enabled edge lands on 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= LAST;
    else        r_cnt <= w_nxt;
  end

  assign o_cnt      = r_cnt;
  assign o_wrap     = i_inc && w_at_last;
  assign o_nxt_vis  = (w_nxt < VIS);
  assign o_nxt_sync = in_window(w_nxt, SYN_LO, SYN_HI);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator (default 640x480@60, 25.175 MHz pixel clock).
//   clk, rst_n  pixel clock, async active-low reset
//   o_vga       raster bundle (master side of vga_timing_if)
// All outputs are registers. Decodes are computed from the next counter
// values, so every output describes the pix_x/pix_y shown in the same cycle.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_VISIBLE = VGA_H_VISIBLE,
  parameter int   H_FRONT   = VGA_H_FRONT,
  parameter int   H_SYNC    = VGA_H_SYNC,
  parameter int   H_BACK    = VGA_H_BACK,
  parameter int   V_VISIBLE = VGA_V_VISIBLE,
  parameter int   V_FRONT   = VGA_V_FRONT,
  parameter int   V_SYNC    = VGA_V_SYNC,
  parameter int   V_BACK    = VGA_V_BACK,
  parameter logic SYNC_POL  = VGA_SYNC_POL,
  parameter int   FRAME_W   = VGA_FRAME_W
) (
  input  logic         clk,
  input  logic         rst_n,
  vga_timing_if.master o_vga
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_chk_size
    $error("vga_timing_gen: H_TOTAL=%0d / V_TOTAL=%0d exceed 1024", H_TOTAL, V_TOTAL);
  end

  coord_t w_h_cnt, w_v_cnt;
  logic   w_h_wrap, w_v_wrap;
  logic   w_h_nxt_vis, w_v_nxt_vis;
  logic   w_h_nxt_sync, w_v_nxt_sync;

  vga_axis_counter #(
    .TOTAL     (H_TOTAL),
    .VISIBLE   (H_VISIBLE),
    .SYNC_START(H_VISIBLE + H_FRONT),
    .SYNC_END  (H_VISIBLE + H_FRONT + H_SYNC)
  ) u_h (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_inc     (1'b1),
    .o_cnt     (w_h_cnt),
    .o_wrap    (w_h_wrap),
    .o_nxt_vis (w_h_nxt_vis),
    .o_nxt_sync(w_h_nxt_sync)
  );

  vga_axis_counter #(
    .TOTAL     (V_TOTAL),
    .VISIBLE   (V_VISIBLE),
    .SYNC_START(V_VISIBLE + V_FRONT),
    .SYNC_END  (V_VISIBLE + V_FRONT + V_SYNC)
  ) u_v (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_inc     (w_h_wrap),
    .o_cnt     (w_v_cnt),
    .o_wrap    (w_v_wrap),
    .o_nxt_vis (w_v_nxt_vis),
    .o_nxt_sync(w_v_nxt_sync)
  );

  logic               r_video_active;
  logic               r_hsync;
  logic               r_vsync;
  logic               r_line_start;
  logic               r_frame_start;
  logic [FRAME_W-1:0] r_counter;

  // Next x is 0 exactly when x wraps; next (0,0) exactly when y wraps
  // (y only advances on an x wrap).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_video_active <= 1'b0;
      r_hsync        <= ~SYNC_POL;
      r_vsync        <= ~SYNC_POL;
      r_line_start   <= 1'b0;
      r_frame_start  <= 1'b0;
      r_counter      <= '0;
    end else begin
      r_video_active <= w_h_nxt_vis & w_v_nxt_vis;
      r_hsync        <= w_h_nxt_sync ? SYNC_POL : ~SYNC_POL;
      r_vsync        <= w_v_nxt_sync ? SYNC_POL : ~SYNC_POL;
      r_line_start   <= w_h_wrap;
      r_frame_start  <= w_v_wrap;
      if (w_v_wrap) r_counter <= r_counter + 1'b1;
    end
  end

  assign o_vga.pix_x        = w_h_cnt;
  assign o_vga.pix_y        = w_v_cnt;
  assign o_vga.video_active = r_video_active;
  assign o_vga.hsync        = r_hsync;
  assign o_vga.vsync        = r_vsync;
  assign o_vga.line_start   = r_line_start;
  assign o_vga.frame_start  = r_frame_start;
  assign o_vga.counter      = r_counter;

endmodule
